// File: rtl/mem_bank_sequencer.sv
// mem_bank_sequencer
//
// Turns a single bank-select plus read/write request into one-hot enable and
// write-enable strobes for NUM_BANKS block RAMs. Requests use a valid/ready
// handshake. After a read the sequencer waits RD_LATENCY cycles and pulses
// rd_valid/rd_bank in the cycle the RAM output data is valid. A request whose
// bank index is >= NUM_BANKS produces an err_bank pulse and no RAM access.
//
// Optional feature (compile-time macro MEMSEQ_B2B_WRITE_EN):
//   When defined, req_ready is also high in ISSUE while a write is issuing.
//   Back-to-back writes then issue one per cycle.
//
// Ports:
//   clk        in   1          rising-edge clock
//   rst_n      in   1          synchronous active-low reset
//   req_valid  in   1          request present
//   req_ready  out  1          sequencer can accept a request
//   req_bank   in   BANK_W     target bank index
//   req_write  in   1          1 = write, 0 = read
//   bank_ena   out  NUM_BANKS  one-hot bank enable
//   bank_wea   out  NUM_BANKS  one-hot bank write enable (subset of bank_ena)
//   rd_valid   out  1          RAM read data valid this cycle
//   rd_bank    out  BANK_W     bank that produced the read data
//   err_bank   out  1          accepted request targeted a non-existent bank
//   busy       out  1          sequencer not idle
module mem_bank_sequencer #(
  parameter int NUM_BANKS  = 4,
  parameter int BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  parameter int RD_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [BANK_W-1:0]    req_bank,
  input  logic                 req_write,
  output logic [NUM_BANKS-1:0] bank_ena,
  output logic [NUM_BANKS-1:0] bank_wea,
  output logic                 rd_valid,
  output logic [BANK_W-1:0]    rd_bank,
  output logic                 err_bank,
  output logic                 busy
);

  // RD_LATENCY is 1..4, so the remaining-latency counter needs 2 bits.
  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] cnt_load = CNT_W'(RD_LATENCY - 1);

  typedef enum logic [1:0] {
    st_idle  = 2'd0,
    st_issue = 2'd1,
    st_wait  = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [BANK_W-1:0]  bank_reg, bank_next;
  logic               write_reg, write_next;

  logic accept;
  logic bank_ok;
  logic issue_ok;

  // One extra bit so the compare also works when NUM_BANKS is a power of two
  // (every index is then in range and the compare folds to constant true).
  assign bank_ok = ({1'b0, bank_reg} < (BANK_W + 1)'(NUM_BANKS));

`ifdef MEMSEQ_B2B_WRITE_EN
  // A write finishes in its ISSUE cycle, so the next request can be taken
  // there. This includes an out-of-range write, which also ends in ISSUE.
  // A read must still wait for its data.
  assign req_ready = rst_n &&
                     ((state_reg == st_idle) ||
                      ((state_reg == st_issue) && write_reg));
`else
  assign req_ready = rst_n && (state_reg == st_idle);
`endif

  assign accept = req_valid && req_ready;

  // Next-state and capture logic.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bank_next  = bank_reg;
    write_next = write_reg;

    // The request is captured only on an accept, so the strobes below never
    // depend combinationally on req_*.
    if (accept) begin
      bank_next  = req_bank;
      write_next = req_write;
    end

    case (state_reg)
      st_idle: begin
        if (accept) begin
          state_next = st_issue;
        end
      end

      st_issue: begin
        if (accept) begin
          // Reachable only when req_ready is high in ISSUE (a write issuing).
          state_next = st_issue;
        end else if (!bank_ok || write_reg) begin
          state_next = st_idle;
        end else begin
          state_next = st_wait;
          cnt_next   = cnt_load;
        end
      end

      st_wait: begin
        if (cnt_reg == '0) begin
          state_next = st_idle;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      default: begin
        state_next = st_idle;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= st_idle;
      cnt_reg   <= '0;
      bank_reg  <= '0;
      write_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bank_reg  <= bank_next;
      write_reg <= write_next;
    end
  end

  // All outputs are decoded from registered state only.
  assign issue_ok = (state_reg == st_issue) && bank_ok;

  generate
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      localparam logic [BANK_W-1:0] idx = BANK_W'(gi);
      assign bank_ena[gi] = issue_ok && (bank_reg == idx);
      assign bank_wea[gi] = issue_ok && (bank_reg == idx) && write_reg;
    end
  endgenerate

  assign err_bank = (state_reg == st_issue) && !bank_ok;
  assign rd_valid = (state_reg == st_wait) && (cnt_reg == '0);
  // Gate rd_bank so it reads zero whenever rd_valid is low.
  assign rd_bank  = rd_valid ? bank_reg : '0;
  assign busy     = (state_reg != st_idle);

endmodule

// File: tb/tb_mem_bank_sequencer.sv
module tb_mem_bank_sequencer;

  localparam int NB = 4;
  localparam int BW = 2;
  localparam int RL = 2;
  localparam int NB3 = 3;

`ifdef MEMSEQ_B2B_WRITE_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          req_valid, req_ready, req_write;
  logic [BW-1:0] req_bank;
  logic [NB-1:0] bank_ena, bank_wea;
  logic          rd_valid, err_bank, busy;
  logic [BW-1:0] rd_bank;

  logic           req_valid3, req_ready3, req_write3;
  logic [BW-1:0]  req_bank3;
  logic [NB3-1:0] bank_ena3, bank_wea3;
  logic           rd_valid3, err_bank3, busy3;
  logic [BW-1:0]  rd_bank3;

  mem_bank_sequencer #(.NUM_BANKS(NB), .BANK_W(BW), .RD_LATENCY(RL)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_bank(req_bank), .req_write(req_write),
    .bank_ena(bank_ena), .bank_wea(bank_wea),
    .rd_valid(rd_valid), .rd_bank(rd_bank),
    .err_bank(err_bank), .busy(busy)
  );

  mem_bank_sequencer #(.NUM_BANKS(NB3), .BANK_W(BW), .RD_LATENCY(RL)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid3), .req_ready(req_ready3),
    .req_bank(req_bank3), .req_write(req_write3),
    .bank_ena(bank_ena3), .bank_wea(bank_wea3),
    .rd_valid(rd_valid3), .rd_bank(rd_bank3),
    .err_bank(err_bank3), .busy(busy3)
  );

  typedef struct {
    int            cyc;
    logic [NB-1:0] ena;
    logic [NB-1:0] wea;
    logic          rdv;
    logic [BW-1:0] rdb;
  } exp_t;

  exp_t sb[$];
  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int free_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Every strobe/rd_valid/err event on the main DUT must match the next
  // scoreboard entry, including the cycle it appears in.
  always @(negedge clk) begin
    exp_t e;
    if (bank_ena != '0 || bank_wea != '0 || rd_valid || err_bank) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_event cyc=%0d ena=%b wea=%b rd_valid=%b rd_bank=%0d err=%b",
                 cyc, bank_ena, bank_wea, rd_valid, rd_bank, err_bank);
      end else begin
        e = sb.pop_front();
        if (cyc !== e.cyc || bank_ena !== e.ena || bank_wea !== e.wea ||
            rd_valid !== e.rdv || rd_bank !== e.rdb || err_bank !== 1'b0) begin
          n_errors++;
          $display("FAIL event cyc=%0d ena=%b wea=%b rdv=%b rdb=%0d err=%b expected cyc=%0d ena=%b wea=%b rdv=%b rdb=%0d err=0",
                   cyc, bank_ena, bank_wea, rd_valid, rd_bank, err_bank,
                   e.cyc, e.ena, e.wea, e.rdv, e.rdb);
        end else begin
          $display("txn cyc=%0d ena=%b wea=%b rd_valid=%b rd_bank=%0d", cyc, bank_ena, bank_wea, rd_valid, rd_bank);
        end
      end
    end
  end

  // Present a request at negedge+1 and hold it until the model says the DUT
  // accepts; req_ready is checked against the model every cycle.
  task automatic send(input logic [BW-1:0] b, input logic w);
    exp_t e;
    logic [NB-1:0] oh;
    int acc;
    bit ok;
    req_valid = 1'b1;
    req_bank  = b;
    req_write = w;
    #1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      n_checks++;
      if (req_ready !== (cyc >= free_cyc)) begin
        n_errors++;
        $display("FAIL req_ready cyc=%0d got=%b expected=%b", cyc, req_ready, (cyc >= free_cyc));
      end
      if (cyc >= free_cyc) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout bank=%0d write=%b", b, w);
      req_valid = 1'b0;
      return;
    end
    acc = cyc + 1;
    oh = 1;
    oh = oh << b;
    e.cyc = acc; e.ena = oh; e.wea = w ? oh : '0; e.rdv = 1'b0; e.rdb = '0;
    sb.push_back(e);
    if (!w) begin
      e.cyc = acc + RL; e.ena = '0; e.wea = '0; e.rdv = 1'b1; e.rdb = b;
      sb.push_back(e);
      free_cyc = acc + 1 + RL;
    end else begin
      free_cyc = B2B ? acc : acc + 1;
    end
    @(negedge clk); #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) begin
      @(negedge clk); #1;
    end
  endtask

  task automatic drain();
    idle(8);
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL missing_events got=0 expected=%0d pending", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b0; req_bank = '0; req_write = 1'b0;
    req_valid3 = 1'b0; req_bank3 = '0; req_write3 = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({bank_ena, bank_wea, rd_valid, rd_bank, err_bank, busy, req_ready} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs ena=%b wea=%b rdv=%b rdb=%0d err=%b busy=%b ready=%b expected all 0",
               bank_ena, bank_wea, rd_valid, rd_bank, err_bank, busy, req_ready);
    end
    n_checks++;
    if ({bank_ena3, bank_wea3, rd_valid3, rd_bank3, err_bank3, busy3, req_ready3} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs3 got=%b expected 0",
               {bank_ena3, bank_wea3, rd_valid3, rd_bank3, err_bank3, busy3, req_ready3});
    end
    rst_n = 1'b1;
    #1;
    free_cyc = cyc;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL ready_after_reset got=%b expected=1", req_ready);
    end
  endtask

  task automatic test_write();
    send(2'd2, 1'b1);
    req_valid = 1'b0;
    n_checks++;
    if (bank_ena !== 4'b0100 || bank_wea !== 4'b0100 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL write_k1 ena=%b wea=%b busy=%b expected 0100 0100 1", bank_ena, bank_wea, busy);
    end
    @(negedge clk); #1;
    n_checks++;
    if (bank_ena !== '0 || bank_wea !== '0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL write_k2 ena=%b wea=%b ready=%b busy=%b expected 0000 0000 1 0", bank_ena, bank_wea, req_ready, busy);
    end
    send(2'd3, 1'b1);
    drain();
  endtask

  task automatic test_read();
    send(2'd3, 1'b0);
    req_valid = 1'b0;
    n_checks++;
    if (bank_ena !== 4'b1000 || bank_wea !== 4'b0000 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL read_k1 ena=%b wea=%b busy=%b expected 1000 0000 1", bank_ena, bank_wea, busy);
    end
    repeat (3) begin
      @(negedge clk); #1;
    end
    n_checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || rd_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL read_k4 ready=%b busy=%b rd_valid=%b expected 1 0 0", req_ready, busy, rd_valid);
    end
    send(2'd0, 1'b0);
    send(2'd1, 1'b0);
    drain();
  endtask

  task automatic test_err_bank();
    bit seen;
    // Out-of-range read, then out-of-range write, on the 3-bank instance.
    for (int t = 0; t < 2; t++) begin
      req_valid3 = 1'b1; req_bank3 = 2'd3; req_write3 = (t == 1);
      #1;
      n_checks++;
      if (req_ready3 !== 1'b1) begin
        n_errors++;
        $display("FAIL err_ready_k got=%b expected=1", req_ready3);
      end
      @(negedge clk); #1;
      req_valid3 = 1'b0;
      n_checks++;
      if (err_bank3 !== 1'b1 || bank_ena3 !== '0 || bank_wea3 !== '0 || busy3 !== 1'b1) begin
        n_errors++;
        $display("FAIL err_k1 err=%b ena=%b wea=%b busy=%b expected 1 000 000 1", err_bank3, bank_ena3, bank_wea3, busy3);
      end
      @(negedge clk); #1;
      n_checks++;
      if (err_bank3 !== 1'b0 || req_ready3 !== 1'b1 || busy3 !== 1'b0) begin
        n_errors++;
        $display("FAIL err_k2 err=%b ready=%b busy=%b expected 0 1 0", err_bank3, req_ready3, busy3);
      end
      seen = 1'b0;
      repeat (4) begin
        if (rd_valid3 || err_bank3 || bank_ena3 != '0) seen = 1'b1;
        @(negedge clk); #1;
      end
      n_checks++;
      if (seen) begin
        n_errors++;
        $display("FAIL err_no_followup got=spurious_output expected=none");
      end
    end
    // A valid write on the 3-bank instance still decodes normally.
    req_valid3 = 1'b1; req_bank3 = 2'd2; req_write3 = 1'b1;
    @(negedge clk); #1;
    req_valid3 = 1'b0;
    n_checks++;
    if (bank_ena3 !== 3'b100 || bank_wea3 !== 3'b100 || err_bank3 !== 1'b0) begin
      n_errors++;
      $display("FAIL err_valid_write ena=%b wea=%b err=%b expected 100 100 0", bank_ena3, bank_wea3, err_bank3);
    end
    idle(3);
  endtask

  task automatic test_reset_mid_read();
    exp_t dropped;
    send(2'd1, 1'b0);
    req_valid = 1'b0;
    dropped = sb.pop_back();   // the rd_valid of this read must never appear
    @(negedge clk); #1;        // cycle k+2: reset sampled at edge k+2
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      n_checks++;
      if ({bank_ena, bank_wea, rd_valid, rd_bank, err_bank, busy, req_ready} !== '0) begin
        n_errors++;
        $display("FAIL reset_mid_read ena=%b wea=%b rdv=%b rdb=%0d err=%b busy=%b ready=%b expected all 0 (dropped bank %0d)",
                 bank_ena, bank_wea, rd_valid, rd_bank, err_bank, busy, req_ready, dropped.rdb);
      end
    end
    rst_n = 1'b1;
    #1;
    free_cyc = cyc;
    send(2'd0, 1'b1);
    drain();
  endtask

  task automatic test_hold();
    send(2'd3, 1'b0);
    // Bank 1 held valid while busy: exactly one accept once ready returns.
    send(2'd1, 1'b1);
    drain();
  endtask

  task automatic test_back_to_back();
    send(2'd0, 1'b1);
    send(2'd1, 1'b1);
    send(2'd2, 1'b1);
    drain();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_err_bank();
    test_reset_mid_read();
    test_hold();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached");
    $fatal(1, "timeout");
  end

endmodule
